fir_frame_sequencer: RTL and testbench

Frame-level controller placed in front of and behind one `FirFilter` instance. It accepts framed samples over a valid/ready stream and clears the filter's delay line before each frame. After the last sample it injects NUM_TAPS-1 zero samples so the full convolution tail emerges. Because `FirFilter` has no backpressure, the block buffers filter outputs in a credit-protected FIFO and presents them downstream with a valid/ready handshake and an end-of-frame marker.

---
 rtl/fir_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_sequencer.sv
// Frame sequencer around a FirFilter: clears the delay line per frame, appends the
// NUM_TAPS-1 zero flush tail and buffers filter outputs in a credit-protected FWFT FIFO.
module fir_frame_sequencer #(
  parameter int INPUT_WIDTH    = 16,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int NUM_TAPS       = 16,
  parameter int OUT_FIFO_DEPTH = 32,
  parameter int CLEAR_CYCLES   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  input  logic                    s_last,
  output logic                    fir_rst,
  output logic                    fir_valid_in,
  output logic [INPUT_WIDTH-1:0]  fir_din,
  input  logic                    fir_valid_out,
  input  logic [OUTPUT_WIDTH-1:0] fir_dout,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    err
);

  localparam int PW    = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int FL_W  = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CLR_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic [FL_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]           in_flight_q, in_flight_d;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]    issued_q, issued_d;
  logic [CNT_WIDTH-1:0]    received_q, received_d;
  logic                    last_written_q, last_written_d;
  logic                    err_q, err_d;
  logic                    fir_rst_q, fir_rst_d;
  logic                    fir_valid_in_q, fir_valid_in_d;
  logic [INPUT_WIDTH-1:0]  fir_din_q, fir_din_d;
  logic [OUTPUT_WIDTH:0]   mem_q [OUT_FIFO_DEPTH];

  logic                    credit;
  logic [CW:0]             occupancy;
  logic                    issue;
  logic [INPUT_WIDTH-1:0]  issue_data;
  logic                    clear_frame;
  logic                    ret;
  logic                    push_ok;
  logic                    push_last;
  logic                    pop;

  // Outstanding filter results are counted against FIFO space so it can never overflow.
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, in_flight_q};
  assign credit    = occupancy < (CW+1)'(OUT_FIFO_DEPTH);
  assign s_ready   = (state_q == ST_RUN) && credit;

  assign m_valid      = (fifo_cnt_q != '0);
  assign m_data       = m_valid ? mem_q[rd_ptr_q][OUTPUT_WIDTH-1:0] : '0;
  assign m_last       = m_valid & mem_q[rd_ptr_q][OUTPUT_WIDTH];
  assign err          = err_q;
  assign fir_rst      = fir_rst_q;
  assign fir_valid_in = fir_valid_in_q;
  assign fir_din      = fir_din_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    flush_cnt_d = flush_cnt_q;
    issue       = 1'b0;
    issue_data  = '0;
    clear_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = '0;
          clear_frame = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + CLR_W'(1);
        if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (s_valid && credit) begin
          issue       = 1'b1;
          issue_data  = s_data;
          flush_cnt_d = '0;
          if (s_last) state_d = (NUM_TAPS == 1) ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (credit) begin
          issue       = 1'b1;
          flush_cnt_d = flush_cnt_q + FL_W'(1);
          if (flush_cnt_q == FL_W'(NUM_TAPS - 2)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_flight_q == '0 && last_written_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ret       = fir_valid_out && (in_flight_q != '0);
    err_d     = err_q | (fir_valid_out && (in_flight_q == '0));
    pop       = m_valid && m_ready;
    push_ok   = ret && ((fifo_cnt_q != CW'(OUT_FIFO_DEPTH)) || pop);
    push_last = (state_q == ST_DRAIN) && ((received_q + CNT_WIDTH'(1)) == issued_q);

    in_flight_d = in_flight_q;
    case ({issue, ret})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase

    fifo_cnt_d = fifo_cnt_q;
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    issued_d       = clear_frame ? '0 : (issue ? issued_q + CNT_WIDTH'(1) : issued_q);
    received_d     = clear_frame ? '0 : (ret ? received_q + CNT_WIDTH'(1) : received_q);
    last_written_d = clear_frame ? 1'b0 : (last_written_q | (push_ok & push_last));

    fir_rst_d      = (state_q == ST_CLEAR);
    fir_valid_in_d = issue;
    fir_din_d      = issue_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      clr_cnt_q      <= '0;
      flush_cnt_q    <= '0;
      in_flight_q    <= '0;
      fifo_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      issued_q       <= '0;
      received_q     <= '0;
      last_written_q <= 1'b0;
      err_q          <= 1'b0;
      fir_rst_q      <= 1'b1;
      fir_valid_in_q <= 1'b0;
      fir_din_q      <= '0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      in_flight_q    <= in_flight_d;
      fifo_cnt_q     <= fifo_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      issued_q       <= issued_d;
      received_q     <= received_d;
      last_written_q <= last_written_d;
      err_q          <= err_d;
      fir_rst_q      <= fir_rst_d;
      fir_valid_in_q <= fir_valid_in_d;
      fir_din_q      <= fir_din_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) mem_q[wr_ptr_q] <= {push_last, fir_dout};
  end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Directed bench for fir_frame_sequencer driving a 4-tap (1,2,3,4) filter stand-in
// with one cycle of latency; expected outputs are hand-computed or from a reference sum.
module tb_fir_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, s_last;
  logic        fir_rst, fir_valid_in, fir_valid_out;
  logic        m_valid, m_ready, m_last, err;
  logic [15:0] s_data, fir_din, fir_dout, m_data;

  always #5 clk = ~clk;

  fir_frame_sequencer #(
    .INPUT_WIDTH   (16),
    .OUTPUT_WIDTH  (16),
    .NUM_TAPS      (4),
    .OUT_FIFO_DEPTH(8),
    .CLEAR_CYCLES  (4),
    .CNT_WIDTH     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .fir_rst      (fir_rst),
    .fir_valid_in (fir_valid_in),
    .fir_din      (fir_din),
    .fir_valid_out(fir_valid_out),
    .fir_dout     (fir_dout),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .err          (err)
  );

  // Filter stand-in: y = 1*x[n] + 2*x[n-1] + 3*x[n-2] + 4*x[n-3], one cycle latency.
  logic [15:0] x0, x1, x2, fo;
  logic        fv, spur;
  always @(posedge clk) begin
    if (fir_rst) begin
      x0 <= '0; x1 <= '0; x2 <= '0; fo <= '0; fv <= 1'b0;
    end else begin
      fv <= fir_valid_in;
      if (fir_valid_in) begin
        fo <= 16'(int'(fir_din) + 2 * int'(x0) + 3 * int'(x1) + 4 * int'(x2));
        x0 <= fir_din; x1 <= x0; x2 <= x1;
      end
    end
  end
  assign fir_valid_out = fv | spur;
  assign fir_dout      = fo;

  logic [15:0] rx_d[$];
  logic        rx_l[$];
  int          rst_hi = 0;
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      rx_d.push_back(m_data);
      rx_l.push_back(m_last);
    end
    if (fir_rst) rst_hi++;
  end

  logic [15:0] tx_d[$];
  logic        tx_l[$];
  int          tx_idx;
  int          n_err = 0;
  int          n_chk = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic stream(input int limit, input int max_acc, output int acc_cnt);
    int   cyc;
    logic acc;
    cyc = 0;
    acc_cnt = 0;
    while (tx_idx < tx_d.size() && cyc < limit && acc_cnt < max_acc) begin
      s_valid = 1'b1;
      s_data  = tx_d[tx_idx];
      s_last  = tx_l[tx_idx];
      acc     = s_ready;
      tick();
      if (acc) begin
        tx_idx++;
        acc_cnt++;
      end
      cyc++;
    end
    if (tx_idx >= tx_d.size() || acc_cnt >= max_acc) begin
      s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    end
  endtask

  task automatic wait_rx(input string tag, input int base, input int n, input int limit);
    int cyc;
    cyc = 0;
    while (rx_d.size() - base < n && cyc < limit) begin
      tick();
      cyc++;
    end
    repeat (10) tick();
    chk({tag, "_rx_count"}, rx_d.size() - base, n);
  endtask

  function automatic logic [15:0] fir_ref(input int n);
    int coef[4];
    int acc;
    coef = '{1, 2, 3, 4};
    acc = 0;
    for (int k = 0; k < 4; k++)
      if (n - k >= 0 && n - k < tx_d.size()) acc += coef[k] * int'(tx_d[n - k]);
    return 16'(acc);
  endfunction

  task automatic do_single(input string tag);
    logic [15:0] e[7];
    int base, rbase, n, acc;
    e = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0};
    tx_d = '{16'd1, 16'd0, 16'd0, 16'd0};
    tx_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    tx_idx = 0;
    base  = rx_d.size();
    rbase = rst_hi;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'd1; s_last = 1'b0;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready_latency"}, n, 5);
    stream(100, 100, acc);
    chk({tag, "_accepted"}, acc, 4);
    wait_rx(tag, base, 7, 100);
    for (int i = 0; i < 7; i++) begin
      if (base + i < rx_d.size()) begin
        chk($sformatf("%s_data%0d", tag, i), rx_d[base + i], e[i]);
        chk($sformatf("%s_last%0d", tag, i), rx_l[base + i], (i == 6) ? 1 : 0);
      end
    end
    chk({tag, "_clear_cycles"}, rst_hi - rbase, 4);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, rbase, acc;
    logic [15:0] e2[14];
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1; spur = 1'b0;
    repeat (3) tick();
    chk("rst_fir_rst", fir_rst, 1);
    chk("rst_fir_valid_in", fir_valid_in, 0);
    chk("rst_fir_din", fir_din, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_fir_rst", fir_rst, 0);
    chk("post_rst_s_ready", s_ready, 0);

    do_single("single");

    // Backpressure: 20-sample frame, 8-entry FIFO, sink stalled.
    tx_d.delete(); tx_l.delete();
    for (int i = 0; i < 20; i++) begin
      tx_d.push_back(16'(i + 1));
      tx_l.push_back(i == 19);
    end
    tx_idx = 0;
    base = rx_d.size();
    m_ready = 1'b0;
    stream(40, 100, acc);
    chk("bp_accepted_stalled", acc, 8);
    chk("bp_s_ready_low", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_nothing_popped", rx_d.size() - base, 0);
    m_ready = 1'b1;
    stream(300, 100, acc);
    chk("bp_accepted_rest", acc, 12);
    wait_rx("bp", base, 23, 300);
    for (int i = 0; i < 23; i++) begin
      if (base + i < rx_d.size()) begin
        chk($sformatf("bp_data%0d", i), rx_d[base + i], fir_ref(i));
        chk($sformatf("bp_last%0d", i), rx_l[base + i], (i == 22) ? 1 : 0);
      end
    end
    chk("bp_err", err, 0);

    // Back-to-back frames of 3 and 5 samples, s_valid held high throughout.
    e2 = '{16'd1, 16'd4, 16'd10, 16'd16, 16'd17, 16'd12,
           16'd5, 16'd10, 16'd15, 16'd20, 16'd1, 16'd2, 16'd3, 16'd4};
    tx_d = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd0, 16'd0, 16'd0, 16'd1};
    tx_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tx_idx = 0;
    base  = rx_d.size();
    rbase = rst_hi;
    stream(300, 100, acc);
    chk("b2b_accepted", acc, 8);
    wait_rx("b2b", base, 14, 200);
    for (int i = 0; i < 14; i++) begin
      if (base + i < rx_d.size()) begin
        chk($sformatf("b2b_data%0d", i), rx_d[base + i], e2[i]);
        chk($sformatf("b2b_last%0d", i), rx_l[base + i], (i == 5 || i == 13) ? 1 : 0);
      end
    end
    chk("b2b_clear_cycles", rst_hi - rbase, 8);

    // Mid-frame reset with results already buffered.
    tx_d = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd7};
    tx_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tx_idx = 0;
    m_ready = 1'b0;
    base = rx_d.size();
    stream(100, 2, acc);
    chk("mid_accepted", acc, 2);
    repeat (4) tick();
    chk("mid_pre_rst_m_valid", m_valid, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_fir_rst", fir_rst, 1);
    chk("mid_rst_fir_valid_in", fir_valid_in, 0);
    chk("mid_rst_fir_din", fir_din, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    chk("mid_fifo_empty", m_valid, 0);
    chk("mid_no_stale_pop", rx_d.size() - base, 0);
    do_single("after_rst");

    // Spurious filter output while idle.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_err_set", err, 1);
    chk("spur_m_valid", m_valid, 0);
    repeat (5) tick();
    chk("spur_err_sticky", err, 1);
    chk("spur_m_valid_later", m_valid, 0);
    rst = 1'b0;
    tick();
    chk("spur_err_rst", err, 0);
    rst = 1'b1;
    tick();
    chk("spur_err_after_rst", err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
